decode_buffer_stage: RTL and testbench

Parametrised decode stage that replaces the single F->D pipeline register with a DEPTH-entry instruction FIFO under a valid/ready handshake. The head entry is decoded combinationally through ctrl and regfile, with immediate generation and an optional same-cycle WB->D register bypass. It sits between fetch and the D->E pipeline register, decoupling fetch from backend stalls.

---
 rtl/decode_buffer_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_decode_buffer_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_buffer_stage.sv
// Decode stage with a DEPTH-entry instruction FIFO between fetch and D->E.
// The head entry is decoded combinationally; operands come from the regfile with optional WB bypass.
module decode_buffer_stage #(
    parameter int XLEN      = 32,
    parameter int ILEN      = 32,
    parameter int REG_BITS  = 5,
    parameter int DEPTH     = 2,
    parameter int BYPASS_WB = 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ILEN-1:0]     instr_in,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [XLEN-1:0]     pc_plus4_in,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic [XLEN-1:0]     result_WB_in,
    input  logic [REG_BITS-1:0] rd_WB_in,
    input  logic                reg_write_WB_in,
    output logic [REG_BITS-1:0] rd_out,
    output logic [REG_BITS-1:0] rs1_out,
    output logic [REG_BITS-1:0] rs2_out,
    output logic [XLEN-1:0]     pc_out,
    output logic [XLEN-1:0]     pc_plus4_out,
    output logic [XLEN-1:0]     rs1_data_out,
    output logic [XLEN-1:0]     rs2_data_out,
    output logic [XLEN-1:0]     imm_out,
    output logic                reg_write_out,
    output logic                mem_write_out,
    output logic                is_branch_out,
    output logic                is_jump_out,
    output logic [1:0]          result_src_out,
    output logic [3:0]          alu_ctrl_out,
    output logic [1:0]          alu_src1_out,
    output logic                alu_src2_out,
    output logic [2:0]          data_size_out,
    output logic [1:0]          xcpt_out,
    output logic [CNT_W-1:0]    count_out
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3,
                           IMM_U = 3'd4, IMM_NONE = 3'd7;
    localparam logic [1:0] RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [1:0] SRC1_RS1 = 2'd0, SRC1_PC = 2'd1, SRC1_ZERO = 2'd2;
    localparam logic [1:0] XCPT_NONE = 2'd0, XCPT_ILLEGAL = 2'd1, XCPT_ECALL = 2'd2,
                           XCPT_EBREAK = 2'd3;

    logic [ILEN-1:0]     instr_mem [DEPTH];
    logic [XLEN-1:0]     pc_mem    [DEPTH];
    logic [XLEN-1:0]     pc4_mem   [DEPTH];
    logic [XLEN-1:0]     rf        [2**REG_BITS];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;
    logic                push, pop;
    logic [31:0]         instr;
    logic [2:0]          imm_src;
    logic                writes_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic signed [31:0] imm_gen(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            default: return '0;
        endcase
    endfunction

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // x0 reads zero; a same-cycle WB write to a nonzero source wins over the stored value
    function automatic logic [XLEN-1:0] operand(input logic [REG_BITS-1:0] rs,
                                                input logic [XLEN-1:0] stored);
        if (rs == '0) return '0;
        if (BYPASS_WB != 0 && reg_write_WB_in && rd_WB_in == rs) return result_WB_in;
        return stored;
    endfunction

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count_out = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush_in) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_in) begin
            instr_mem[wr_ptr] <= instr_in;
            pc_mem[wr_ptr]    <= pc_in;
            pc4_mem[wr_ptr]   <= pc_plus4_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reg_write_WB_in && rd_WB_in != '0) rf[rd_WB_in] <= result_WB_in;
    end

    // Head decode: an empty buffer presents a NOP with zero PCs
    assign instr        = out_valid ? instr_mem[rd_ptr][31:0] : NOP_INSTR;
    assign pc_out       = out_valid ? pc_mem[rd_ptr]  : '0;
    assign pc_plus4_out = out_valid ? pc4_mem[rd_ptr] : '0;
    assign rd_out       = REG_BITS'(instr[11:7]);
    assign rs1_out      = REG_BITS'(instr[19:15]);
    assign rs2_out      = REG_BITS'(instr[24:20]);
    assign rs1_data_out = operand(rs1_out, rf[rs1_out]);
    assign rs2_data_out = operand(rs2_out, rf[rs2_out]);
    assign imm_out      = XLEN'(imm_gen(instr, imm_src));
    assign reg_write_out = writes_rd && (rd_out != '0);

    always_comb begin
        writes_rd      = 1'b0;
        mem_write_out  = 1'b0;
        is_branch_out  = 1'b0;
        is_jump_out    = 1'b0;
        result_src_out = RES_ALU;
        alu_ctrl_out   = ALU_ADD;
        alu_src1_out   = SRC1_RS1;
        alu_src2_out   = 1'b0;
        data_size_out  = 3'b010;
        xcpt_out       = XCPT_NONE;
        imm_src        = IMM_NONE;
        case (instr[6:0])
            7'b0110011: begin
                writes_rd    = 1'b1;
                alu_ctrl_out = alu_op(instr[14:12], instr[30]);
            end
            7'b0010011: begin
                writes_rd    = 1'b1;
                imm_src      = IMM_I;
                alu_src2_out = 1'b1;
                alu_ctrl_out = alu_op(instr[14:12], (instr[14:12] == 3'b101) & instr[30]);
            end
            7'b0000011: begin
                writes_rd      = 1'b1;
                imm_src        = IMM_I;
                alu_src2_out   = 1'b1;
                result_src_out = RES_MEM;
                data_size_out  = instr[14:12];
            end
            7'b0100011: begin
                mem_write_out = 1'b1;
                imm_src       = IMM_S;
                alu_src2_out  = 1'b1;
                data_size_out = instr[14:12];
            end
            7'b1100011: begin
                is_branch_out = 1'b1;
                imm_src       = IMM_B;
                alu_ctrl_out  = ALU_SUB;
            end
            7'b1101111: begin
                writes_rd      = 1'b1;
                is_jump_out    = 1'b1;
                imm_src        = IMM_J;
                result_src_out = RES_PC4;
                alu_src1_out   = SRC1_PC;
                alu_src2_out   = 1'b1;
            end
            7'b1100111: begin
                writes_rd      = 1'b1;
                is_jump_out    = 1'b1;
                imm_src        = IMM_I;
                result_src_out = RES_PC4;
                alu_src2_out   = 1'b1;
            end
            7'b0110111: begin
                writes_rd    = 1'b1;
                imm_src      = IMM_U;
                alu_src1_out = SRC1_ZERO;
                alu_src2_out = 1'b1;
            end
            7'b0010111: begin
                writes_rd    = 1'b1;
                imm_src      = IMM_U;
                alu_src1_out = SRC1_PC;
                alu_src2_out = 1'b1;
            end
            7'b1110011: begin
                if (instr[14:12] == 3'b000) xcpt_out = instr[20] ? XCPT_EBREAK : XCPT_ECALL;
            end
            7'b0001111: ;
            default:    xcpt_out = XCPT_ILLEGAL;
        endcase
    end
endmodule

// File: tb/tb_decode_buffer_stage.sv
// Directed bench for decode_buffer_stage: scoreboard queue filled by stimulus, drained by a monitor.
module tb_decode_buffer_stage;
    localparam int XLEN = 32, ILEN = 32, RB = 5, DEPTH = 2;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk, reset, flush_in, in_valid, out_ready, reg_write_WB_in;
    logic [ILEN-1:0] instr_in;
    logic [XLEN-1:0] pc_in, pc_plus4_in, result_WB_in;
    logic [RB-1:0]   rd_WB_in;

    logic in_ready, out_valid, reg_write_out, mem_write_out, is_branch_out, is_jump_out, alu_src2_out;
    logic [RB-1:0] rd_out, rs1_out, rs2_out;
    logic [XLEN-1:0] pc_out, pc_plus4_out, rs1_data_out, rs2_data_out, imm_out;
    logic [1:0] result_src_out, alu_src1_out, xcpt_out;
    logic [3:0] alu_ctrl_out;
    logic [2:0] data_size_out;
    logic [CW-1:0] count_out;

    logic nb_in_ready, nb_out_valid, nb_reg_write, nb_mem_write, nb_is_branch, nb_is_jump, nb_alu_src2;
    logic [RB-1:0] nb_rd, nb_rs1, nb_rs2;
    logic [XLEN-1:0] nb_pc, nb_pc4, nb_rs1_data, nb_rs2_data, nb_imm;
    logic [1:0] nb_result_src, nb_alu_src1, nb_xcpt;
    logic [3:0] nb_alu_ctrl;
    logic [2:0] nb_data_size;
    logic [CW-1:0] nb_count;

    decode_buffer_stage #(.XLEN(XLEN), .ILEN(ILEN), .REG_BITS(RB), .DEPTH(DEPTH), .BYPASS_WB(1)) u_dut (
        .clk(clk), .reset(reset), .flush_in(flush_in), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .pc_plus4_in(pc_plus4_in), .out_valid(out_valid),
        .out_ready(out_ready), .result_WB_in(result_WB_in), .rd_WB_in(rd_WB_in),
        .reg_write_WB_in(reg_write_WB_in), .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .rs1_data_out(rs1_data_out),
        .rs2_data_out(rs2_data_out), .imm_out(imm_out), .reg_write_out(reg_write_out),
        .mem_write_out(mem_write_out), .is_branch_out(is_branch_out), .is_jump_out(is_jump_out),
        .result_src_out(result_src_out), .alu_ctrl_out(alu_ctrl_out), .alu_src1_out(alu_src1_out),
        .alu_src2_out(alu_src2_out), .data_size_out(data_size_out), .xcpt_out(xcpt_out),
        .count_out(count_out));

    decode_buffer_stage #(.XLEN(XLEN), .ILEN(ILEN), .REG_BITS(RB), .DEPTH(DEPTH), .BYPASS_WB(0)) u_nb (
        .clk(clk), .reset(reset), .flush_in(flush_in), .in_valid(in_valid), .in_ready(nb_in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .pc_plus4_in(pc_plus4_in), .out_valid(nb_out_valid),
        .out_ready(out_ready), .result_WB_in(result_WB_in), .rd_WB_in(rd_WB_in),
        .reg_write_WB_in(reg_write_WB_in), .rd_out(nb_rd), .rs1_out(nb_rs1), .rs2_out(nb_rs2),
        .pc_out(nb_pc), .pc_plus4_out(nb_pc4), .rs1_data_out(nb_rs1_data),
        .rs2_data_out(nb_rs2_data), .imm_out(nb_imm), .reg_write_out(nb_reg_write),
        .mem_write_out(nb_mem_write), .is_branch_out(nb_is_branch), .is_jump_out(nb_is_jump),
        .result_src_out(nb_result_src), .alu_ctrl_out(nb_alu_ctrl), .alu_src1_out(nb_alu_src1),
        .alu_src2_out(nb_alu_src2), .data_size_out(nb_data_size), .xcpt_out(nb_xcpt),
        .count_out(nb_count));

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        rw;
        logic        br;
        logic        chk;
        logic [31:0] rs1;
        logic [31:0] rs1_nb;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        in_valid    = 1'b1;
        instr_in    = ins;
        pc_in       = pc;
        pc_plus4_in = pc + 32'd4;
    endtask

    task automatic expect_item(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] imm,
                               input logic rw, input logic br, input logic chk,
                               input logic [31:0] rs1, input logic [31:0] rs1_nb);
        exp_t e;
        e.pc = pc; e.rd = rd; e.imm = imm; e.rw = rw; e.br = br;
        e.chk = chk; e.rs1 = rs1; e.rs1_nb = rs1_nb;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted head is compared against the oldest expected entry
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_head_pc", pc_out, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("head_pc", pc_out, e.pc);
                check("head_pc4", pc_plus4_out, e.pc + 32'd4);
                check("head_rd", 32'(rd_out), 32'(e.rd));
                check("head_imm", imm_out, e.imm);
                check("head_reg_write", 32'(reg_write_out), 32'(e.rw));
                check("head_is_branch", 32'(is_branch_out), 32'(e.br));
                if (e.chk) begin
                    check("head_rs1_data", rs1_data_out, e.rs1);
                    check("head_rs1_data_nobypass", nb_rs1_data, e.rs1_nb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr_in = '0; pc_in = '0; pc_plus4_in = '0;
        reg_write_WB_in = 1'b0; rd_WB_in = '0; result_WB_in = '0;
        #2;
        check("reset_count", 32'(count_out), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_reg_write", 32'(reg_write_out), 0);
        check("reset_pc", pc_out, 0);
        tick();
        reset = 1'b1;
        tick();

        // Preload x1, x2
        reg_write_WB_in = 1'b1; rd_WB_in = 5'd1; result_WB_in = 32'h1111_1111;
        tick();
        rd_WB_in = 5'd2; result_WB_in = 32'h2222_2222;
        tick();
        reg_write_WB_in = 1'b0;

        // Fill under back-pressure; third push refused
        drive(32'h0050_0093, 32'h100);
        expect_item(32'h100, 5'd1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        tick();
        drive(32'hABCD_E2B7, 32'h104);
        expect_item(32'h104, 5'd5, 32'hABCD_E000, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        drive(32'hFE00_0CE3, 32'h108);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_count", 32'(count_out), 2);
        tick();
        check("full_count_hold", 32'(count_out), 2);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("drain_count1", 32'(count_out), 1);
        tick();
        check("drain_count0", 32'(count_out), 0);
        check("drain_out_valid", 32'(out_valid), 0);

        // Streaming: one instruction per cycle
        for (int i = 0; i < 8; i++) begin
            drive(32'h0000_0093 | (32'(i) << 20), 32'(i * 4));
            expect_item(32'(i * 4), 5'd1, 32'(i), 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
            tick();
            check("stream_count", 32'(count_out), 1);
            check("stream_out_valid", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_count", 32'(count_out), 0);

        // WB bypass on rs1 = x1
        out_ready = 1'b0;
        drive(32'h0020_81B3, 32'h200);
        expect_item(32'h200, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111);
        tick();
        in_valid = 1'b0;
        reg_write_WB_in = 1'b1; rd_WB_in = 5'd1; result_WB_in = 32'hDEAD_BEEF; out_ready = 1'b1;
        tick();
        reg_write_WB_in = 1'b0; out_ready = 1'b0;

        // WB to x0 is neither forwarded nor written
        drive(32'h0020_01B3, 32'h204);
        expect_item(32'h204, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        reg_write_WB_in = 1'b1; rd_WB_in = 5'd0; result_WB_in = 32'hCAFE_F00D; out_ready = 1'b1;
        tick();
        reg_write_WB_in = 1'b0; out_ready = 1'b0;

        // x1 was written by the earlier WB in both instances
        drive(32'h0020_81B3, 32'h208);
        expect_item(32'h208, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush with concurrent push
        drive(32'h0050_0093, 32'h300);
        tick();
        drive(32'h0050_0093, 32'h304);
        tick();
        check("preflush_count", 32'(count_out), 2);
        drive(32'h0050_0093, 32'h308);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count_out), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        tick();
        check("flush_count_hold", 32'(count_out), 0);

        // Branch with negative B immediate; only this entry may emerge after the flush
        drive(32'hFE00_0CE3, 32'h400);
        expect_item(32'h400, 5'd25, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("branch_drain_count", 32'(count_out), 0);

        // Asynchronous reset mid-stream with two entries buffered
        out_ready = 1'b0;
        drive(32'h0050_0093, 32'h500);
        tick();
        drive(32'h0050_0093, 32'h504);
        tick();
        in_valid = 1'b0;
        check("prereset_count", 32'(count_out), 2);
        #2 reset = 1'b0;
        #1;
        check("async_reset_count", 32'(count_out), 0);
        check("async_reset_out_valid", 32'(out_valid), 0);
        #2 reset = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 1);
        check("post_reset_reg_write", 32'(reg_write_out), 0);
        tick();
        check("post_reset_count", 32'(count_out), 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
